// File: rtl/jam_pkg.sv
// Shared widths and state encoding for the job-assignment engine and its cost server.
package jam_pkg;

    localparam int N_WORKERS = 8;
    localparam int COST_W    = 7;
    localparam int MINCOST_W = 10;
    localparam int MCNT_W    = 4;
    localparam int IDX_W     = 6;
    localparam int N_ENTRIES = N_WORKERS * N_WORKERS;

    typedef enum logic [1:0] {
        LOAD,
        RELEASE,
        RUN,
        DONE
    } jam_state_t;

    // Table address is the plain {worker, job} concatenation, row-major.
    function automatic logic [IDX_W-1:0] table_index(input logic [2:0] w, input logic [2:0] j);
        return {w, j};
    endfunction

endpackage

// File: rtl/jam_cost_server_if.sv
// Bundle of the load port, engine cost/result port and status outputs of the cost server.
interface jam_cost_server_if #(
    parameter int CW = jam_pkg::COST_W
);
    import jam_pkg::*;

    logic                 load_valid;
    logic [CW-1:0]        load_data;
    logic [MINCOST_W-1:0] gold_min;
    logic [MCNT_W-1:0]    gold_cnt;
    logic                 jam_rst;
    logic [2:0]           W;
    logic [2:0]           J;
    logic [CW-1:0]        Cost;
    logic                 Valid;
    logic [MINCOST_W-1:0] MinCost;
    logic [MCNT_W-1:0]    MatchCount;
    logic                 done;
    logic                 pass;
    logic                 timeout;

    modport master (
        output load_valid, load_data, gold_min, gold_cnt,
        output W, J, Valid, MinCost, MatchCount,
        input  jam_rst, Cost, done, pass, timeout
    );

    modport slave (
        input  load_valid, load_data, gold_min, gold_cnt,
        input  W, J, Valid, MinCost, MatchCount,
        output jam_rst, Cost, done, pass, timeout
    );

endinterface

// File: rtl/jam_cost_table.sv
// 64-entry cost register file: one serial write port, one zero-latency read port.
module jam_cost_table
    import jam_pkg::*;
#(
    parameter int CW = COST_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CW-1:0]    wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [CW-1:0]    rdata
);

    logic [CW-1:0] mem [N_ENTRIES];

    // Write one entry per enabled cycle; reset clears every entry so Cost reads 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The engine samples Cost one edge after presenting W/J, so the read must be a pure mux.
    assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// Cost server: loads the cost table, holds the engine in reset, then checks its result.
module jam_cost_server
    import jam_pkg::*;
#(
    parameter int TIMEOUT = 60000,
    parameter int CW      = COST_W
) (
    input logic CLK,
    input logic RST,
    jam_cost_server_if.slave bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = '1;

    jam_state_t           state;
    logic [IDX_W-1:0]     load_idx;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [MINCOST_W-1:0] gold_min_q;
    logic [MCNT_W-1:0]    gold_cnt_q;
    logic                 jam_rst_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;
    logic                 table_we;
    logic [CW-1:0]        cost_rd;

    // The table is writable only while loading; afterwards it is frozen.
    assign table_we = (state == LOAD) && bus.load_valid;

    jam_cost_table #(
        .CW(CW)
    ) u_table (
        .CLK   (CLK),
        .RST   (RST),
        .we    (table_we),
        .waddr (load_idx),
        .wdata (bus.load_data),
        .raddr (table_index(bus.W, bus.J)),
        .rdata (cost_rd)
    );

    // Sequencing: load, one release cycle, run with timeout watch, then hold the verdict.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= LOAD;
            load_idx   <= '0;
            cycle_cnt  <= '0;
            gold_min_q <= '0;
            gold_cnt_q <= '0;
            jam_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.load_valid) begin
                        load_idx <= load_idx + 1'b1;
                        if (load_idx == IDX_LAST) begin
                            gold_min_q <= bus.gold_min;
                            gold_cnt_q <= bus.gold_cnt;
                            state      <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    cycle_cnt <= '0;
                    jam_rst_q <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (cycle_cnt != CNT_MAX) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    if (bus.Valid) begin
                        pass_q <= (bus.MinCost == gold_min_q) && (bus.MatchCount == gold_cnt_q);
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (cycle_cnt >= CNT_LAST) begin
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    assign bus.Cost    = cost_rd;
    assign bus.jam_rst = jam_rst_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized scoreboard bench for jam_cost_server against a table/rule-level reference model.
module tb_jam_cost_server;
    import jam_pkg::*;

    localparam int TIMEOUT = 100;
    localparam int CW      = COST_W;

    typedef struct {
        int            idx;
        logic [CW-1:0] cost;
    } cost_exp_t;

    typedef struct {
        logic pass;
        logic tmo;
        int   cycles;
    } res_exp_t;

    logic CLK;
    logic RST;

    jam_cost_server_if #(.CW(CW)) bus ();

    jam_cost_server #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    cost_exp_t     costQ[$];
    res_exp_t      resQ[$];
    logic [CW-1:0] model [64];
    int            nChecks = 0;
    int            nFails  = 0;
    int            runCycles = 0;
    logic          prevDone = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares Cost probes every cycle and the verdict when done first rises.
    always @(negedge CLK) begin
        cost_exp_t ce;
        res_exp_t  re;
        if (costQ.size() > 0) begin
            ce = costQ.pop_front();
            checkOutput($sformatf("cost[%0d]", ce.idx), int'(bus.Cost), int'(ce.cost));
        end
        if (bus.done && !prevDone) begin
            if (resQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_done actual=1 required=0 at %0t", $time);
            end else begin
                re = resQ.pop_front();
                checkOutput("pass", int'(bus.pass), int'(re.pass));
                checkOutput("timeout", int'(bus.timeout), int'(re.tmo));
                checkOutput("run_cycles", runCycles, re.cycles);
            end
        end
        prevDone = bus.done;
        if (bus.jam_rst) begin
            runCycles = 0;
        end else if (!bus.done) begin
            runCycles++;
        end
    end

    task automatic applyStimulus(input logic lv, input logic [CW-1:0] ld, input logic [2:0] w,
                                 input logic [2:0] j, input logic v, input logic [9:0] mc,
                                 input logic [3:0] cnt, input bit probe);
        cost_exp_t e;
        @(posedge CLK);
        #1;
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.W          = w;
        bus.J          = j;
        bus.Valid      = v;
        bus.MinCost    = mc;
        bus.MatchCount = cnt;
        if (probe) begin
            e.idx  = int'(w) * 8 + int'(j);
            e.cost = model[e.idx];
            costQ.push_back(e);
        end
    endtask

    task automatic doReset(input bit fullScan);
        #2;
        RST            = 1'b1;
        bus.load_valid = 1'b0;
        bus.Valid      = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        #1;
        checkOutput("rst_jam_rst", int'(bus.jam_rst), 1);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_pass", int'(bus.pass), 0);
        checkOutput("rst_timeout", int'(bus.timeout), 0);
        for (int i = 0; i < (fullScan ? 64 : 1); i++) begin
            bus.W = 3'(i / 8);
            bus.J = 3'(i % 8);
            #1;
            checkOutput($sformatf("rst_cost[%0d]", i), int'(bus.Cost), int'(model[i]));
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // mode 0 = ramp, 1 = all ones, otherwise random; gaps inserted randomly between beats.
    task automatic loadTable(input int mode, input logic [9:0] gMin, input logic [3:0] gCnt);
        logic [CW-1:0] d;
        for (int k = 0; k < 64; k++) begin
            case (mode)
                0:       d = CW'(k % 128);
                1:       d = CW'(1);
                default: d = CW'($urandom_range(0, 127));
            endcase
            model[k] = d;
            repeat ($urandom_range(0, 2))
                applyStimulus(1'b0, CW'($urandom), 3'($urandom), 3'($urandom), 1'b0, 10'd0, 4'd0, 1'b0);
            applyStimulus(1'b1, d, 3'($urandom), 3'($urandom), 1'b0, 10'd0, 4'd0, 1'b0);
            if (k == 63) begin
                bus.gold_min = gMin;
                bus.gold_cnt = gCnt;
            end else begin
                bus.gold_min = 10'($urandom);
                bus.gold_cnt = 4'($urandom);
            end
        end
        @(negedge CLK);
        checkOutput("jam_rst_last_beat", int'(bus.jam_rst), 1);
        applyStimulus(1'b0, CW'(0), 3'd0, 3'd0, 1'b0, 10'd0, 4'd0, 1'b0);
        bus.gold_min = ~gMin;
        bus.gold_cnt = ~gCnt;
        @(negedge CLK);
        checkOutput("jam_rst_release", int'(bus.jam_rst), 1);
    endtask

    // validCycle < 0 means Valid never rises; after Valid the result bus drifts to the gold values.
    task automatic runPhase(input int validCycle, input logic [9:0] mc, input logic [3:0] cnt,
                            input logic [9:0] gMin, input logic [3:0] gCnt);
        res_exp_t   r;
        logic       v;
        logic [9:0] m;
        logic [3:0] c;
        logic [2:0] w;
        logic [2:0] j;
        if (validCycle >= 0 && validCycle < TIMEOUT) begin
            r.pass   = (mc == gMin) && (cnt == gCnt);
            r.tmo    = 1'b0;
            r.cycles = validCycle + 1;
        end else begin
            r.pass   = 1'b0;
            r.tmo    = 1'b1;
            r.cycles = TIMEOUT;
        end
        resQ.push_back(r);
        for (int k = 0; k < TIMEOUT + 6; k++) begin
            v = (validCycle >= 0) && (k >= validCycle);
            m = mc;
            c = cnt;
            if (validCycle >= 0 && k > validCycle) begin
                m = gMin;
                c = gCnt;
            end
            w = (k == 0) ? 3'd3 : 3'($urandom);
            j = (k == 0) ? 3'd5 : 3'($urandom);
            applyStimulus(1'($urandom), CW'($urandom), w, j, v, m, c, 1'b1);
            @(negedge CLK);
            if (k == 0) checkOutput("jam_rst_run", int'(bus.jam_rst), 0);
        end
        if (resQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL result_missing actual=0 required=1 at %0t", $time);
            resQ.delete();
        end
        checkOutput("hold_done", int'(bus.done), 1);
        checkOutput("hold_pass", int'(bus.pass), int'(r.pass));
        checkOutput("hold_timeout", int'(bus.timeout), int'(r.tmo));
    endtask

    initial begin
        logic [9:0] gm;
        logic [3:0] gc;
        int         vc;
        RST            = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.gold_min   = '0;
        bus.gold_cnt   = '0;
        bus.W          = '0;
        bus.J          = '0;
        bus.Valid      = 1'b0;
        bus.MinCost    = '0;
        bus.MatchCount = '0;
        doReset(1'b1);

        gm = 10'($urandom);
        gc = 4'($urandom);
        $display("[TB] ramp load, matching result");
        loadTable(0, gm, gc);
        runPhase(10, gm, gc, gm, gc);

        $display("[TB] all-ones load, correct result");
        doReset(1'b0);
        loadTable(1, 10'd8, 4'd0);
        runPhase(3, 10'd8, 4'd0, 10'd8, 4'd0);

        $display("[TB] all-ones load, wrong MinCost then corrected");
        doReset(1'b0);
        loadTable(1, 10'd8, 4'd0);
        runPhase(5, 10'd9, 4'd0, 10'd8, 4'd0);

        $display("[TB] no Valid, timeout");
        doReset(1'b0);
        loadTable(2, gm, gc);
        runPhase(-1, gm, gc, gm, gc);

        $display("[TB] Valid on the final timeout cycle");
        doReset(1'b0);
        loadTable(2, gm, gc);
        runPhase(TIMEOUT - 1, gm, gc, gm, gc);

        $display("[TB] Valid one cycle too late");
        doReset(1'b0);
        loadTable(2, gm, gc);
        runPhase(TIMEOUT, gm, gc, gm, gc);

        for (int n = 0; n < 4; n++) begin
            gm = 10'($urandom);
            gc = 4'($urandom);
            vc = $urandom_range(0, TIMEOUT + 2);
            doReset(1'b0);
            loadTable(2, gm, gc);
            if (n[0]) runPhase(vc, gm, gc, gm, gc);
            else      runPhase(vc, gm ^ 10'(1 << $urandom_range(0, 9)), gc, gm, gc);
        end

        $display("[TB] reset during RUN with load pulses");
        doReset(1'b0);
        loadTable(2, gm, gc);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, CW'($urandom), (k >= 6) ? 3'd0 : 3'($urandom),
                          (k == 6) ? 3'd0 : ((k == 7) ? 3'd1 : 3'($urandom)),
                          1'b0, 10'd0, 4'd0, 1'b1);
            @(negedge CLK);
        end
        doReset(1'b1);
        loadTable(0, gm, gc);
        runPhase(2, gm, gc, gm, gc);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=expired required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
